rab_lookup_arbiter: RTL and testbench

Sequencer and arbiter for the shared RAB slice lookup datapath. It accepts translation requests from the read (AR) and write (AW) channel front-ends and grants one at a time, round-robin. It drives the single `slice_top` lookup port from registered inputs, samples and classifies the result, and holds it on a valid/ready response port until it is consumed.

---
 rtl/rab_lookup_arbiter.sv | 161 ++++++++++++++++
 tb/tb_rab_lookup_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rab_lookup_arbiter.sv
// rab_lookup_arbiter
//   Round-robin arbiter and sequencer in front of the shared RAB slice lookup.
//   Read (Rd*) and write (Wr*) front-ends present address ranges. One request
//   is granted at a time, and a three-state FSM walks it through IDLE, LOOKUP
//   and RESP. The Lut_* port is driven from registers that were captured at
//   the grant. The lookup result is sampled at the end of LOOKUP, classified,
//   and then held on the Resp_* valid/ready port until it is consumed.
//
// Ports
//   Clk_CI, Rst_RBI                 clock, async active-low reset
//   {Rd,Wr}Req_valid/ready          request handshake per channel
//   {Rd,Wr}Req_addr_min/max, _id    burst range and transaction id
//   Lut_rw, Lut_addr_min/max        registered drive into the lookup
//   Lut_hit, Lut_prot, Lut_multi_hit, Lut_cache_coherent, Lut_out_addr
//                                   lookup result, sampled at the end of LOOKUP
//   Resp_valid/ready, Resp_rw, Resp_id, Resp_addr, Resp_cc, Resp_err
//                                   classified response (err: 00 ok, 01 miss,
//                                   10 prot, 11 multi-hit)
//
// Build option RAB_LOOKUP_STATS_EN adds the following saturating counters,
//   each updated on the response handshake:
//   Stat_rd_miss/Stat_wr_miss (non-ok responses per direction) and
//   Stat_multi (multi-hit responses). Stat_clr clears all of them.
module rab_lookup_arbiter #(
  parameter int N_SLICES        = 16,
  parameter int ADDR_WIDTH_PHYS = 40,
  parameter int ADDR_WIDTH_VIRT = 32,
  parameter int ID_WIDTH        = 8
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RBI,
  input  logic                       RdReq_valid,
  output logic                       RdReq_ready,
  input  logic [ADDR_WIDTH_VIRT-1:0] RdReq_addr_min,
  input  logic [ADDR_WIDTH_VIRT-1:0] RdReq_addr_max,
  input  logic [ID_WIDTH-1:0]        RdReq_id,
  input  logic                       WrReq_valid,
  output logic                       WrReq_ready,
  input  logic [ADDR_WIDTH_VIRT-1:0] WrReq_addr_min,
  input  logic [ADDR_WIDTH_VIRT-1:0] WrReq_addr_max,
  input  logic [ID_WIDTH-1:0]        WrReq_id,
  output logic                       Lut_rw,
  output logic [ADDR_WIDTH_VIRT-1:0] Lut_addr_min,
  output logic [ADDR_WIDTH_VIRT-1:0] Lut_addr_max,
  input  logic [N_SLICES-1:0]        Lut_hit,
  input  logic [N_SLICES-1:0]        Lut_prot,
  input  logic                       Lut_multi_hit,
  input  logic                       Lut_cache_coherent,
  input  logic [ADDR_WIDTH_PHYS-1:0] Lut_out_addr,
  output logic                       Resp_valid,
  input  logic                       Resp_ready,
  output logic                       Resp_rw,
  output logic [ID_WIDTH-1:0]        Resp_id,
  output logic [ADDR_WIDTH_PHYS-1:0] Resp_addr,
  output logic                       Resp_cc,
  output logic [1:0]                 Resp_err
`ifdef RAB_LOOKUP_STATS_EN
  ,
  input  logic                       Stat_clr,
  output logic [31:0]                Stat_rd_miss,
  output logic [31:0]                Stat_wr_miss,
  output logic [15:0]                Stat_multi
`endif
);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t              state_q;
  logic                last_wr_q;  // 1: last grant went to the write channel
  logic [ID_WIDTH-1:0] id_q;
  logic                rd_gnt, wr_gnt;
  logic [1:0]          err_d;

  // When both channels are valid, the channel that was not granted last wins.
  assign rd_gnt = RdReq_valid & (~WrReq_valid | last_wr_q);
  assign wr_gnt = WrReq_valid & (~RdReq_valid | ~last_wr_q);

  assign RdReq_ready = (state_q == IDLE) & rd_gnt;
  assign WrReq_ready = (state_q == IDLE) & wr_gnt;

  // Classification priority: multi-hit, then hit, then prot, then miss.
  always_comb begin
    err_d = 2'b01;
    if (Lut_multi_hit)  err_d = 2'b11;
    else if (|Lut_hit)  err_d = 2'b00;
    else if (|Lut_prot) err_d = 2'b10;
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q      <= IDLE;
      last_wr_q    <= 1'b1;  // read channel wins the first tie
      id_q         <= '0;
      Lut_rw       <= 1'b0;
      Lut_addr_min <= '0;
      Lut_addr_max <= '0;
      Resp_valid   <= 1'b0;
      Resp_rw      <= 1'b0;
      Resp_id      <= '0;
      Resp_addr    <= '0;
      Resp_cc      <= 1'b0;
      Resp_err     <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (RdReq_ready || WrReq_ready) begin
            Lut_rw       <= WrReq_ready;
            Lut_addr_min <= WrReq_ready ? WrReq_addr_min : RdReq_addr_min;
            Lut_addr_max <= WrReq_ready ? WrReq_addr_max : RdReq_addr_max;
            id_q         <= WrReq_ready ? WrReq_id : RdReq_id;
            last_wr_q    <= WrReq_ready;
            state_q      <= LOOKUP;
          end
        end
        LOOKUP: begin
          // The Lut_* registers have been stable for this whole cycle, so
          // the combinational lookup result is valid at this edge.
          Resp_valid <= 1'b1;
          Resp_rw    <= Lut_rw;
          Resp_id    <= id_q;
          Resp_err   <= err_d;
          Resp_addr  <= (err_d == 2'b00) ? Lut_out_addr : '0;
          Resp_cc    <= (err_d == 2'b00) ? Lut_cache_coherent : 1'b0;
          state_q    <= RESP;
        end
        RESP: begin
          if (Resp_ready) begin
            Resp_valid <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RAB_LOOKUP_STATS_EN
  logic resp_hs;
  assign resp_hs = Resp_valid & Resp_ready;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      Stat_rd_miss <= '0;
      Stat_wr_miss <= '0;
      Stat_multi   <= '0;
    end else if (Stat_clr) begin
      Stat_rd_miss <= '0;
      Stat_wr_miss <= '0;
      Stat_multi   <= '0;
    end else if (resp_hs) begin
      if (Resp_err != 2'b00 && !Resp_rw && Stat_rd_miss != '1)
        Stat_rd_miss <= Stat_rd_miss + 32'd1;
      if (Resp_err != 2'b00 && Resp_rw && Stat_wr_miss != '1)
        Stat_wr_miss <= Stat_wr_miss + 32'd1;
      if (Resp_err == 2'b11 && Stat_multi != '1)
        Stat_multi <= Stat_multi + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rab_lookup_arbiter.sv
module tb_rab_lookup_arbiter;
  localparam int NS = 16, AP = 40, AV = 32, IW = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          RdReq_valid = 0, WrReq_valid = 0, RdReq_ready, WrReq_ready;
  logic [AV-1:0] RdReq_addr_min = 0, RdReq_addr_max = 0;
  logic [AV-1:0] WrReq_addr_min = 0, WrReq_addr_max = 0;
  logic [IW-1:0] RdReq_id = 0, WrReq_id = 0;
  logic          Lut_rw;
  logic [AV-1:0] Lut_addr_min, Lut_addr_max;
  logic [NS-1:0] Lut_hit = 0, Lut_prot = 0;
  logic          Lut_multi_hit = 0, Lut_cache_coherent = 0;
  logic [AP-1:0] Lut_out_addr = 0;
  logic          Resp_valid, Resp_ready = 0, Resp_rw, Resp_cc;
  logic [IW-1:0] Resp_id;
  logic [AP-1:0] Resp_addr;
  logic [1:0]    Resp_err;
`ifdef RAB_LOOKUP_STATS_EN
  logic          Stat_clr = 0;
  logic [31:0]   Stat_rd_miss, Stat_wr_miss;
  logic [15:0]   Stat_multi;
`endif

  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  rab_lookup_arbiter #(.N_SLICES(NS), .ADDR_WIDTH_PHYS(AP), .ADDR_WIDTH_VIRT(AV), .ID_WIDTH(IW)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .RdReq_valid(RdReq_valid), .RdReq_ready(RdReq_ready),
    .RdReq_addr_min(RdReq_addr_min), .RdReq_addr_max(RdReq_addr_max), .RdReq_id(RdReq_id),
    .WrReq_valid(WrReq_valid), .WrReq_ready(WrReq_ready),
    .WrReq_addr_min(WrReq_addr_min), .WrReq_addr_max(WrReq_addr_max), .WrReq_id(WrReq_id),
    .Lut_rw(Lut_rw), .Lut_addr_min(Lut_addr_min), .Lut_addr_max(Lut_addr_max),
    .Lut_hit(Lut_hit), .Lut_prot(Lut_prot), .Lut_multi_hit(Lut_multi_hit),
    .Lut_cache_coherent(Lut_cache_coherent), .Lut_out_addr(Lut_out_addr),
    .Resp_valid(Resp_valid), .Resp_ready(Resp_ready), .Resp_rw(Resp_rw), .Resp_id(Resp_id),
    .Resp_addr(Resp_addr), .Resp_cc(Resp_cc), .Resp_err(Resp_err)
`ifdef RAB_LOOKUP_STATS_EN
    , .Stat_clr(Stat_clr), .Stat_rd_miss(Stat_rd_miss), .Stat_wr_miss(Stat_wr_miss),
    .Stat_multi(Stat_multi)
`endif
  );

  // Reference classification, straight from the response-code rules.
  function automatic logic [1:0] model_err(input logic multi, input logic [NS-1:0] hit,
                                           input logic [NS-1:0] prot);
    if (multi) return 2'b11;
    if (hit != 0) return 2'b00;
    if (prot != 0) return 2'b10;
    return 2'b01;
  endfunction

  task automatic set_lut(input logic [NS-1:0] hit, input logic [NS-1:0] prot,
                         input logic multi, input logic cc, input logic [AP-1:0] oaddr);
    Lut_hit = hit; Lut_prot = prot; Lut_multi_hit = multi;
    Lut_cache_coherent = cc; Lut_out_addr = oaddr;
  endtask

  task automatic do_reset;
    RdReq_valid = 0; WrReq_valid = 0; Resp_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Present one request starting at a negedge. The task returns at the negedge
  // just after the handshake edge, which is the LOOKUP cycle.
  task automatic send(input bit wr, input logic [AV-1:0] amin, input logic [AV-1:0] amax,
                      input logic [IW-1:0] id);
    bit ok = 0;
    if (wr) begin WrReq_valid = 1; WrReq_addr_min = amin; WrReq_addr_max = amax; WrReq_id = id; end
    else    begin RdReq_valid = 1; RdReq_addr_min = amin; RdReq_addr_max = amax; RdReq_id = id; end
    for (int i = 0; i < 20; i++) begin
      #1;
      if (wr ? WrReq_ready : RdReq_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) begin @(posedge clk); @(negedge clk); end
    RdReq_valid = 0; WrReq_valid = 0;
    vecs++;
    if (!ok) begin errs++; $display("FAIL send_timeout wr=%0d got no ready, required ready within 20 cycles", wr); end
  endtask

  task automatic consume;
    Resp_ready = 1;
    @(negedge clk);
    Resp_ready = 0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    vecs++;
    if ({Resp_valid, Resp_rw, Resp_id, Resp_addr, Resp_cc, Resp_err, Lut_rw, Lut_addr_min, Lut_addr_max} !== '0) begin
      errs++; $display("FAIL reset_outputs resp_valid=%0d err=%0d addr=%h lut_min=%h, required all zero",
                       Resp_valid, Resp_err, Resp_addr, Lut_addr_min);
    end
    RdReq_valid = 1; WrReq_valid = 1;
    #1;
    vecs++;
    if ({RdReq_ready, WrReq_ready} !== 2'b10) begin
      errs++; $display("FAIL reset_first_grant got %b, required 10", {RdReq_ready, WrReq_ready});
    end
    RdReq_valid = 0; WrReq_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    set_lut(16'h0004, 16'h0, 1'b0, 1'b1, 40'hAB_0000_1000);
    send(0, 32'h1000, 32'h103F, 8'h5A);
    vecs++;
    if ({Resp_valid, Lut_rw, Lut_addr_min, Lut_addr_max} !== {1'b0, 1'b0, 32'h1000, 32'h103F}) begin
      errs++; $display("FAIL basic_lookup_cycle valid=%0d rw=%0d min=%h max=%h, required 0 0 1000 103f",
                       Resp_valid, Lut_rw, Lut_addr_min, Lut_addr_max);
    end
    @(negedge clk);
    vecs++;
    if ({Resp_valid, Resp_err, Resp_addr, Resp_cc, Resp_rw, Resp_id} !==
        {1'b1, 2'b00, 40'hAB_0000_1000, 1'b1, 1'b0, 8'h5A}) begin
      errs++; $display("FAIL basic_resp valid=%0d err=%0d addr=%h cc=%0d rw=%0d id=%h, required 1 0 ab00001000 1 0 5a",
                       Resp_valid, Resp_err, Resp_addr, Resp_cc, Resp_rw, Resp_id);
    end
    consume;
    vecs++;
    if (Resp_valid !== 1'b0) begin errs++; $display("FAIL basic_consumed valid=%0d, required 0", Resp_valid); end
  endtask

  task automatic test_classify;
    logic [NS-1:0] hit, prot;
    logic multi, cc, wr;
    logic [AP-1:0] oaddr, eaddr;
    logic [AV-1:0] amin, amax;
    logic [IW-1:0] id;
    logic [1:0] eerr;
    int erd = 0, ewr = 0, emul = 0;
`ifdef RAB_LOOKUP_STATS_EN
    Stat_clr = 1; @(negedge clk); Stat_clr = 0;
`endif
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom); cc = 1'($urandom); id = IW'($urandom);
      amin = $urandom; amax = amin + AV'($urandom_range(0, 255));
      oaddr = {8'($urandom), 32'($urandom)};
      hit   = ($urandom_range(0, 2) == 0) ? '0 : NS'($urandom);
      prot  = ($urandom_range(0, 1) == 0) ? '0 : NS'($urandom);
      multi = ($urandom_range(0, 5) == 0);
      // Directed corner cases first: prot only, total miss, multi-hit with hits.
      if (n == 0) begin hit = 0; prot = 16'h0001; multi = 0; cc = 1; end
      if (n == 1) begin hit = 0; prot = 0; multi = 0; cc = 1; end
      if (n == 2) begin hit = 16'h0003; multi = 1; cc = 1; end
      set_lut(hit, prot, multi, cc, oaddr);
      eerr  = model_err(multi, hit, prot);
      eaddr = (eerr == 2'b00) ? oaddr : '0;
      if (eerr != 2'b00) begin if (wr) ewr++; else erd++; end
      if (eerr == 2'b11) emul++;
      send(wr, amin, amax, id);
      vecs++;
      if ({Lut_rw, Lut_addr_min, Lut_addr_max} !== {wr, amin, amax}) begin
        errs++; $display("FAIL classify_lut n=%0d got %0d %h %h, required %0d %h %h",
                         n, Lut_rw, Lut_addr_min, Lut_addr_max, wr, amin, amax);
      end
      @(negedge clk);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      vecs++;
      if ({Resp_valid, Resp_err, Resp_addr, Resp_cc, Resp_rw, Resp_id} !==
          {1'b1, eerr, eaddr, (eerr == 2'b00) & cc, wr, id}) begin
        errs++; $display("FAIL classify_resp n=%0d got v=%0d err=%0d addr=%h cc=%0d rw=%0d id=%h, required err=%0d addr=%h",
                         n, Resp_valid, Resp_err, Resp_addr, Resp_cc, Resp_rw, Resp_id, eerr, eaddr);
      end
      consume;
    end
`ifdef RAB_LOOKUP_STATS_EN
    vecs++;
    if ({Stat_rd_miss, Stat_wr_miss, Stat_multi} !== {32'(erd), 32'(ewr), 16'(emul)}) begin
      errs++; $display("FAIL classify_stats got %0d %0d %0d, required %0d %0d %0d",
                       Stat_rd_miss, Stat_wr_miss, Stat_multi, erd, ewr, emul);
    end
`else
    if (erd + ewr + emul < 0) $display("unreachable");
`endif
  endtask

  task automatic test_backpressure;
    logic [AP+IW+5:0] snap;
    bit bad = 0;
    set_lut(16'h0, 16'h0001, 1'b0, 1'b1, 40'h12_3456_789A);
    send(1, 32'h4000, 32'h40FF, 8'hC3);
    @(negedge clk);
    snap = {1'b1, 2'b10, 40'h0, 1'b0, 1'b1, 8'hC3, 1'b0};
    RdReq_valid = 1; WrReq_valid = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if ({Resp_valid, Resp_err, Resp_addr, Resp_cc, Resp_rw, Resp_id, RdReq_ready | WrReq_ready} !== snap)
        bad = 1;
      @(negedge clk);
    end
    vecs++;
    if (bad) begin errs++; $display("FAIL backpressure_hold resp changed or ready seen, now v=%0d err=%0d rdy=%b",
                                    Resp_valid, Resp_err, {RdReq_ready, WrReq_ready}); end
    Resp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({Resp_valid, RdReq_ready, WrReq_ready} !== 3'b010) begin
      errs++; $display("FAIL backpressure_release got v,rd,wr=%b, required 010", {Resp_valid, RdReq_ready, WrReq_ready});
    end
    RdReq_valid = 0; WrReq_valid = 0; Resp_ready = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic exp_q[$];
    logic exp_wr = 0, r;
    int last = -1, grants = 0;
    do_reset;
    set_lut(16'h0100, 16'h0, 1'b0, 1'b0, 40'h00_0000_0040);
    RdReq_id = 8'h11; WrReq_id = 8'h22;
    Resp_ready = 1; RdReq_valid = 1; WrReq_valid = 1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      #1;
      if (Resp_valid) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++; $display("FAIL b2b_extra_resp cyc=%0d rw=%0d, required no response", cyc, Resp_rw);
        end else begin
          r = exp_q.pop_front();
          if ({Resp_rw, Resp_id} !== {r, r ? 8'h22 : 8'h11}) begin
            errs++; $display("FAIL b2b_resp cyc=%0d rw=%0d id=%h, required rw=%0d", cyc, Resp_rw, Resp_id, r);
          end
        end
      end
      if (RdReq_ready || WrReq_ready) begin
        vecs++;
        if ({RdReq_ready, WrReq_ready} !== (exp_wr ? 2'b01 : 2'b10) || (last >= 0 && cyc - last != 3)) begin
          errs++; $display("FAIL b2b_grant cyc=%0d got %b gap=%0d, required %b gap 3",
                           cyc, {RdReq_ready, WrReq_ready}, cyc - last, exp_wr ? 2'b01 : 2'b10);
        end
        exp_q.push_back(exp_wr);
        exp_wr = ~exp_wr; last = cyc; grants++;
      end
      @(negedge clk);
    end
    RdReq_valid = 0; WrReq_valid = 0; Resp_ready = 0;
    vecs++;
    if (grants != 15 || exp_q.size() != 0) begin
      errs++; $display("FAIL b2b_count grants=%0d pending=%0d, required 15 and 0", grants, exp_q.size());
    end
  endtask

  task automatic test_mid_reset;
    bit bad = 0;
    set_lut(16'h0002, 16'h0, 1'b0, 1'b1, 40'h55_0000_2000);
    send(1, 32'h2000, 32'h20FF, 8'h33);
    #2 rst_n = 0;
    #1;
    vecs++;
    if ({Resp_valid, RdReq_ready, WrReq_ready, Lut_rw, Lut_addr_min, Lut_addr_max, Resp_addr, Resp_id} !== '0) begin
      errs++; $display("FAIL midreset_async v=%0d lut_rw=%0d lut_min=%h, required all zero",
                       Resp_valid, Lut_rw, Lut_addr_min);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (Resp_valid !== 1'b0) bad = 1;
      @(negedge clk);
    end
    vecs++;
    if (bad) begin errs++; $display("FAIL midreset_no_resp got a response after reset, required none"); end
  endtask

`ifdef RAB_LOOKUP_STATS_EN
  task automatic test_stats;
    Stat_clr = 1; @(negedge clk); Stat_clr = 0;
    set_lut(16'h0, 16'h0, 1'b0, 1'b0, 40'h0);
    for (int i = 0; i < 3; i++) begin
      send(1, 32'h100 * i, 32'h100 * i + 32'hF, 8'(i));
      @(negedge clk);
      consume;
    end
    vecs++;
    if ({Stat_wr_miss, Stat_rd_miss, Stat_multi} !== {32'd3, 32'd0, 16'd0}) begin
      errs++; $display("FAIL stats_wr_miss got wr=%0d rd=%0d multi=%0d, required 3 0 0",
                       Stat_wr_miss, Stat_rd_miss, Stat_multi);
    end
    Stat_clr = 1; @(negedge clk); Stat_clr = 0;
    vecs++;
    if (Stat_wr_miss !== 32'd0) begin errs++; $display("FAIL stats_clr got %0d, required 0", Stat_wr_miss); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_classify;
    test_backpressure;
    test_back_to_back;
    test_mid_reset;
`ifdef RAB_LOOKUP_STATS_EN
    test_stats;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
